// File: rtl/vector_loader_pkg.sv
// vector_loader shared types: bank state encoding and count width helper.
package vector_loader_pkg;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2
  } bank_state_t;

  function automatic int count_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/vector_bank.sv
// One half of the vector_loader double buffer: lane storage, fill count
// and EMPTY/FILLING/FULL state.
module vector_bank
  import vector_loader_pkg::*;
#(
  parameter int VL  = 16,
  parameter int FPL = 16,
  parameter int CW  = 5
) (
  input  logic              clk_in,
  input  logic              reset_i,
  input  logic              wr_en,
  input  logic [FPL-1:0]    elem_1,
  input  logic [FPL-1:0]    elem_2,
  input  logic              last,
  input  logic              rd_done,
  output bank_state_t       state,
  output logic [VL*FPL-1:0] vector_1,
  output logic [VL*FPL-1:0] vector_2,
  output logic [CW-1:0]     count,
  output logic              complete
);

  bank_state_t       state_q;
  bank_state_t       state_d;
  logic [VL*FPL-1:0] v1_q;
  logic [VL*FPL-1:0] v2_q;
  logic [CW-1:0]     count_q;

  always_ff @(posedge clk_in) begin
    if (reset_i) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    complete = wr_en & (last | (count_q == CW'(VL - 1)));
    state_d  = state_q;
    unique case (state_q)
      EMPTY:   if (wr_en)    state_d = complete ? FULL : FILLING;
      FILLING: if (complete) state_d = FULL;
      FULL:    if (rd_done)  state_d = EMPTY;
      default:               state_d = EMPTY;
    endcase
  end

  // Clearing on release keeps unused lanes of short vectors at zero.
  always_ff @(posedge clk_in) begin
    if (reset_i || rd_done) begin
      v1_q    <= '0;
      v2_q    <= '0;
      count_q <= '0;
    end else if (wr_en) begin
      count_q <= count_q + CW'(1);
      for (int i = 0; i < VL; i++) begin
        if (count_q == CW'(i)) begin
          v1_q[i*FPL +: FPL] <= elem_1;
          v2_q[i*FPL +: FPL] <= elem_2;
        end
      end
    end
  end

  assign state    = state_q;
  assign vector_1 = v1_q;
  assign vector_2 = v2_q;
  assign count    = count_q;

endmodule

// File: rtl/vector_loader.sv
// Double-buffered packer of (activation, weight) pairs into full-width
// vectors for the downstream dot-product stage.
module vector_loader
  import vector_loader_pkg::*;
#(
  parameter int VECTOR_LENGTH      = 16,
  parameter int FIXED_POINT_LENGTH = 16
) (
  input  logic                                        clk_in,
  input  logic                                        reset_i,
  input  logic [FIXED_POINT_LENGTH-1:0]               element_1_in,
  input  logic [FIXED_POINT_LENGTH-1:0]               element_2_in,
  input  logic                                        element_valid_in,
  input  logic                                        element_last_in,
  output logic                                        element_ready_out,
  output logic [VECTOR_LENGTH*FIXED_POINT_LENGTH-1:0] vector_1_out,
  output logic [VECTOR_LENGTH*FIXED_POINT_LENGTH-1:0] vector_2_out,
  output logic                                        vector_valid_out,
  input  logic                                        vector_ready_in,
  output logic [$clog2(VECTOR_LENGTH+1)-1:0]          vector_count_out
);

  localparam int VL  = VECTOR_LENGTH;
  localparam int FPL = FIXED_POINT_LENGTH;
  localparam int VW  = VL * FPL;
  localparam int CW  = count_width(VL);

  logic          wr_ptr;
  logic          rd_ptr;
  logic          in_xfer;
  logic          out_xfer;
  logic [1:0]    wr_en;
  logic [1:0]    rd_done;
  logic [1:0]    complete;
  bank_state_t   st  [2];
  logic [VW-1:0] v1  [2];
  logic [VW-1:0] v2  [2];
  logic [CW-1:0] cnt [2];

  for (genvar g = 0; g < 2; g++) begin : g_bank
    vector_bank #(
      .VL  (VL),
      .FPL (FPL),
      .CW  (CW)
    ) u_bank (
      .clk_in   (clk_in),
      .reset_i  (reset_i),
      .wr_en    (wr_en[g]),
      .elem_1   (element_1_in),
      .elem_2   (element_2_in),
      .last     (element_last_in),
      .rd_done  (rd_done[g]),
      .state    (st[g]),
      .vector_1 (v1[g]),
      .vector_2 (v2[g]),
      .count    (cnt[g]),
      .complete (complete[g])
    );
  end

  always_comb begin
    element_ready_out = ~reset_i & (st[wr_ptr] != FULL);
    vector_valid_out  = (st[rd_ptr] == FULL);
    in_xfer           = element_valid_in & element_ready_out;
    out_xfer          = vector_valid_out & vector_ready_in;
    wr_en             = '0;
    rd_done           = '0;
    for (int i = 0; i < 2; i++) begin
      wr_en[i]   = in_xfer & (wr_ptr == 1'(i));
      rd_done[i] = out_xfer & (rd_ptr == 1'(i));
    end
    vector_1_out     = v1[rd_ptr];
    vector_2_out     = v2[rd_ptr];
    vector_count_out = cnt[rd_ptr];
  end

  // Pointers move independently: write on bank completion, read on consume.
  always_ff @(posedge clk_in) begin
    if (reset_i) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (|complete) wr_ptr <= ~wr_ptr;
      if (out_xfer)  rd_ptr <= ~rd_ptr;
    end
  end

endmodule

// File: tb/tb_vector_loader.sv
// Directed + randomized bench for vector_loader against a queue-based
// model of completed vectors awaiting consumption.
module tb_vector_loader;

  localparam int VL  = 16;
  localparam int FPL = 16;
  localparam int VW  = VL * FPL;
  localparam int CW  = $clog2(VL + 1);

  logic           clk;
  logic           reset_i;
  logic [FPL-1:0] element_1_in;
  logic [FPL-1:0] element_2_in;
  logic           element_valid_in;
  logic           element_last_in;
  logic           element_ready_out;
  logic [VW-1:0]  vector_1_out;
  logic [VW-1:0]  vector_2_out;
  logic           vector_valid_out;
  logic           vector_ready_in;
  logic [CW-1:0]  vector_count_out;

  vector_loader #(
    .VECTOR_LENGTH      (VL),
    .FIXED_POINT_LENGTH (FPL)
  ) dut (
    .clk_in            (clk),
    .reset_i           (reset_i),
    .element_1_in      (element_1_in),
    .element_2_in      (element_2_in),
    .element_valid_in  (element_valid_in),
    .element_last_in   (element_last_in),
    .element_ready_out (element_ready_out),
    .vector_1_out      (vector_1_out),
    .vector_2_out      (vector_2_out),
    .vector_valid_out  (vector_valid_out),
    .vector_ready_in   (vector_ready_in),
    .vector_count_out  (vector_count_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [FPL-1:0] e1;
    logic [FPL-1:0] e2;
    logic           last;
  } pair_t;

  typedef struct {
    logic [VW-1:0] v1;
    logic [VW-1:0] v2;
    int            cnt;
  } vec_t;

  pair_t          stim  [$];
  vec_t           exp_q [$];
  logic [FPL-1:0] acc1  [$];
  logic [FPL-1:0] acc2  [$];
  int             xfer_cyc [$];

  int total  = 0;
  int passed = 0;
  int cyc    = 0;
  int dut_acc = 0;
  int stalls  = 0;

  task automatic chk(input string tag, input logic [VW-1:0] obs,
                     input logic [VW-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic vec_t pack_vec();
    vec_t v;
    v.v1  = '0;
    v.v2  = '0;
    v.cnt = acc1.size();
    for (int k = 0; k < acc1.size(); k++) begin
      v.v1[k*FPL +: FPL] = acc1[k];
      v.v2[k*FPL +: FPL] = acc2[k];
    end
    return v;
  endfunction

  task automatic add(input logic [FPL-1:0] e1, input logic [FPL-1:0] e2,
                     input logic last);
    pair_t p;
    p.e1   = e1;
    p.e2   = e2;
    p.last = last;
    stim.push_back(p);
  endtask

  task automatic run_cycle(input bit rdy, input int vprob);
    bit    v;
    bit    mready;
    bit    acc;
    bit    xf;
    pair_t p;
    v = (stim.size() > 0) && (int'($urandom_range(99)) < vprob);
    if (v) begin
      p = stim[0];
    end else begin
      p.e1   = FPL'($urandom);
      p.e2   = FPL'($urandom);
      p.last = 1'($urandom);
    end
    element_valid_in = v;
    element_1_in     = p.e1;
    element_2_in     = p.e2;
    element_last_in  = p.last;
    vector_ready_in  = rdy;
    #1;
    mready = exp_q.size() < 2;
    chk("elem_ready", VW'(element_ready_out), VW'(mready));
    chk("vec_valid", VW'(vector_valid_out), VW'(exp_q.size() > 0));
    if (exp_q.size() > 0) begin
      chk("vec_1", vector_1_out, exp_q[0].v1);
      chk("vec_2", vector_2_out, exp_q[0].v2);
      chk("vec_count", VW'(vector_count_out), VW'(exp_q[0].cnt));
    end
    if (v && element_ready_out) dut_acc++;
    if (v && !element_ready_out) stalls++;
    acc = v && mready;
    xf  = (exp_q.size() > 0) && rdy;
    if (xf) xfer_cyc.push_back(cyc);
    @(posedge clk);
    if (xf) exp_q.delete(0);
    if (acc) begin
      stim.delete(0);
      acc1.push_back(p.e1);
      acc2.push_back(p.e2);
      if (p.last || acc1.size() == VL) begin
        exp_q.push_back(pack_vec());
        acc1.delete();
        acc2.delete();
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  // mode 0/1: fixed downstream ready, 2: random ready
  task automatic drain(input int mode, input int vprob);
    int n = 0;
    while (stim.size() > 0 && n < 2000) begin
      run_cycle(mode == 2 ? 1'($urandom) : mode[0], vprob);
      n++;
    end
    chk("drain_timeout", VW'(stim.size()), VW'(0));
  endtask

  task automatic flush();
    int n = 0;
    while (exp_q.size() > 0 && n < 100) begin
      run_cycle(1'b1, 0);
      n++;
    end
    chk("flush_timeout", VW'(exp_q.size()), VW'(0));
  endtask

  task automatic do_reset(input int n);
    reset_i          = 1'b1;
    element_valid_in = 1'b0;
    vector_ready_in  = 1'($urandom);
    for (int i = 0; i < n; i++) begin
      #1;
      chk("ready_in_reset", VW'(element_ready_out), VW'(0));
      @(posedge clk);
      @(negedge clk);
    end
    chk("rst_valid", VW'(vector_valid_out), VW'(0));
    chk("rst_vec_1", vector_1_out, VW'(0));
    chk("rst_vec_2", vector_2_out, VW'(0));
    chk("rst_count", VW'(vector_count_out), VW'(0));
    reset_i = 1'b0;
    stim.delete();
    exp_q.delete();
    acc1.delete();
    acc2.delete();
  endtask

  initial begin
    int a0;
    reset_i          = 1'b1;
    element_valid_in = 1'b0;
    element_last_in  = 1'b0;
    element_1_in     = '0;
    element_2_in     = '0;
    vector_ready_in  = 1'b0;
    @(negedge clk);
    do_reset(3);

    // sixteen pairs, weight = lane index
    for (int k = 0; k < VL; k++) add(16'h0400, FPL'(k), 1'b0);
    drain(1, 100);
    flush();

    // short vector of three
    for (int k = 0; k < 3; k++) add(16'h0800, 16'h0C00, k == 2);
    drain(1, 100);
    flush();

    // downstream stalled: only two banks' worth accepted
    for (int k = 0; k < 40; k++) add(FPL'($urandom), FPL'($urandom), k == 39);
    a0 = dut_acc;
    for (int i = 0; i < 36; i++) run_cycle(1'b0, 100);
    chk("stall_accepts", VW'(dut_acc - a0), VW'(32));
    drain(1, 100);
    flush();

    // continuous stream, four vectors
    xfer_cyc.delete();
    stalls = 0;
    for (int k = 0; k < 4 * VL; k++) add(FPL'($urandom), FPL'($urandom), 1'b0);
    drain(1, 100);
    flush();
    chk("stream_stalls", VW'(stalls), VW'(0));
    chk("stream_vectors", VW'(xfer_cyc.size()), VW'(4));
    for (int i = 1; i < xfer_cyc.size(); i++)
      chk("stream_spacing", VW'(xfer_cyc[i] - xfer_cyc[i-1]), VW'(VL));

    // reset while second vector is partly filled
    for (int k = 0; k < VL + 7; k++) add(FPL'($urandom), FPL'($urandom), 1'b0);
    drain(0, 100);
    do_reset(2);
    for (int k = 0; k < VL; k++) add(FPL'($urandom), FPL'($urandom), 1'b0);
    drain(1, 100);
    flush();

    // last on the final lane, then a new short vector
    for (int k = 0; k < VL; k++) add(FPL'($urandom), FPL'($urandom), k == VL - 1);
    add(16'h1111, 16'h2222, 1'b0);
    add(16'h3333, 16'h4444, 1'b1);
    drain(1, 100);
    flush();

    // random traffic on both sides
    for (int k = 0; k < 200; k++)
      add(FPL'($urandom), FPL'($urandom), $urandom_range(7) == 0);
    add(FPL'($urandom), FPL'($urandom), 1'b1);
    drain(2, 70);
    flush();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/vector_loader.md
# vector_loader

Packs a serial stream of fixed-point element pairs (activation, weight) into two full-width vectors for the `vector_multiplier` dot-product stage, which sits directly downstream. Double-buffered: one bank fills from the stream while the other is presented, so sustained input runs at one element per cycle without bubbles. Short vectors are terminated by a last flag and zero-padded so unused lanes contribute nothing to the dot product.

## Interface
- `VECTOR_LENGTH`, 16: elements per vector; ≥2.
- `FIXED_POINT_LENGTH`, 16: bits per element; opaque to this block, never interpreted arithmetically.
- `clk_in`  in  1  sole clock; all logic on rising edge.
- `reset_i`  in  1  synchronous, active-high reset.
- `element_1_in`  in  FIXED_POINT_LENGTH  activation element.
- `element_2_in`  in  FIXED_POINT_LENGTH  weight element.
- `element_valid_in`  in  1  element pair valid.
- `element_last_in`  in  1  pair is final element of its vector; qualified by valid.
- `element_ready_out`  out  1  loader accepts a pair this cycle.
- `vector_1_out`  out  VECTOR_LENGTH*FIXED_POINT_LENGTH  packed activations → `vector_1_in` downstream.
- `vector_2_out`  out  VECTOR_LENGTH*FIXED_POINT_LENGTH  packed weights → `vector_2_in` downstream.
- `vector_valid_out`  out  1  presented vector complete.
- `vector_ready_in`  in  1  downstream consumes presented vector.
- `vector_count_out`  out  $clog2(VECTOR_LENGTH+1)  real (non-padded) elements in presented vector, 1..VECTOR_LENGTH.

## Operation
- Input transfer: `element_valid_in & element_ready_out`. Output transfer: `vector_valid_out & vector_ready_in`.
- Element k of a vector lands in bits `[k*FIXED_POINT_LENGTH +: FIXED_POINT_LENGTH]`; element 0 at LSBs.
- Two banks, each with state EMPTY → FILLING → FULL → EMPTY; write-bank and read-bank pointers toggle independently.
- EMPTY→FILLING on first accepted pair; FILLING→FULL on accepting index VECTOR_LENGTH-1 or any pair with last=1; FULL→EMPTY on output transfer from that bank.
- Write pointer toggles when its bank goes FULL; read pointer toggles on output transfer.
- Bank storage and count cleared on entering EMPTY, so lanes beyond a short vector read as zero.
- Last on index VECTOR_LENGTH-1 is identical to no last; count saturates implicitly, no overflow possible.
- `element_ready_out = ~reset_i & (write bank != FULL)`.
- `vector_valid_out = (read bank == FULL)`; data/count taken from read bank, stable while valid and not consumed.
- Simultaneous input and output transfer on different banks: both take effect same edge.
- Input data/last ignored when valid low; upstream may drop valid without penalty.

## Timing
- Reset values: `vector_valid_out`=0, `vector_1_out`/`vector_2_out`=0, `vector_count_out`=0, `element_ready_out`=0 during reset, 1 on first cycle after.
- Latency: pair completing a bank at edge t → `vector_valid_out`=1 in cycle after t if the other bank is not FULL.
- Freed bank becomes writable the cycle after its output transfer (no same-cycle bypass).
- Both banks FULL → `element_ready_out`=0 until an output transfer.
- Downstream always ready: one vector per VECTOR_LENGTH cycles, input never stalls.
- Reset mid-fill or mid-presentation: all banks EMPTY, pointers to bank 0, partial data discarded; no vector emitted.

## Structure
- Package `vector_loader_pkg`: `bank_state_t` enum (EMPTY, FILLING, FULL); `COUNT_WIDTH` derivation helper.
- Sub-module `vector_bank`: one bank's storage, element count, state; instantiated twice. Top holds pointers and muxing.

## Test plan
- Reset, 16 pairs (elem_1 = 16'h0400, elem_2 = k) with `vector_ready_in`=1 → one vector valid the cycle after 16th accept, count 16, lane k of vector_2 = k, no ready drop.
- 3 pairs, last on third (16'h0800,16'h0C00) → count 3, lanes 3..15 of both vectors = 0.
- `vector_ready_in`=0, stream 40 pairs → ready drops after 32 accepted; first vector held stable; raise ready → 1 vector per transfer, pairs 33–40 accepted in order.
- Continuous stream, 4 vectors, ready always 1 → input never stalls, outputs match order, 4 valid pulses 16 cycles apart.
- Reset asserted after 7 pairs of second vector while first presented → all outputs 0, next 16 pairs form a fresh vector in bank 0.
- Last asserted on element 15 → identical result to no last; next pair starts new vector at lane 0.
